// File: rtl/scale_sequencer.sv
// scale_sequencer
//   Steps a note index through a NUM_NOTES-entry scale ROM at one of two step
//   rates and drives the tone frequency for the PWM tone generator. Command
//   inputs are one-cycle pulses from the keyboard decoder; mode is a level.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active low
//   restart     pulse: index 0, ascending, timer cleared, playing (speed kept)
//   dir_up      pulse: ascending
//   dir_down    pulse: descending
//   speed_fast  pulse: step every PERIOD_FAST clocks
//   speed_slow  pulse: step every PERIOD_SLOW clocks
//   pause_tgl   pulse: toggle playing
//   mode        end-of-scale behaviour (table below)
//   freq        tone frequency in Hz, 0 while paused when MUTE_PAUSE=1
//   note_idx    current note index
//   step_pulse  high for one cycle on each step
//   at_top      note_idx == NUM_NOTES-1
//   at_bottom   note_idx == 0
//   playing     1 running, 0 paused
//
// mode | behaviour when a step runs off the end of the scale
// -----+----------------------------------------------------
//  00  | CLAMP    index holds, direction unchanged
//  01  | WRAP     index jumps to the opposite end
//  10  | PINGPONG direction flips, index moves one step back
//  11  | ONESHOT  index holds, playback pauses itself

module scale_sequencer #(
  parameter int NUM_NOTES   = 15,
  parameter int IDX_W       = 4,
  parameter int FREQ_W      = 32,
  parameter int CNT_W       = 31,
  parameter int PERIOD_FAST = 50_000_000,
  parameter int PERIOD_SLOW = 100_000_000,
  parameter int MUTE_PAUSE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              dir_up,
  input  logic              dir_down,
  input  logic              speed_fast,
  input  logic              speed_slow,
  input  logic              pause_tgl,
  input  logic [1:0]        mode,
  output logic [FREQ_W-1:0] freq,
  output logic [IDX_W-1:0]  note_idx,
  output logic              step_pulse,
  output logic              at_top,
  output logic              at_bottom,
  output logic              playing
);

  typedef enum logic [1:0] {
    MODE_CLAMP    = 2'b00,
    MODE_WRAP     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_t;

  localparam int               ROM_DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W:0]   IDX_TOP   = (IDX_W+1)'(NUM_NOTES - 1);
  localparam logic [IDX_W:0]   IDX_ONE   = (IDX_W+1)'(1);
  localparam logic [CNT_W-1:0] FAST_M1   = CNT_W'(PERIOD_FAST - 1);
  localparam logic [CNT_W-1:0] SLOW_M1   = CNT_W'(PERIOD_SLOW - 1);
  localparam logic [CNT_W-1:0] TMR_ONE   = CNT_W'(1);

  function automatic logic [FREQ_W-1:0] base_hz(input int k);
    case (k)
      0:       base_hz = FREQ_W'(262);
      1:       base_hz = FREQ_W'(294);
      2:       base_hz = FREQ_W'(330);
      3:       base_hz = FREQ_W'(349);
      4:       base_hz = FREQ_W'(392);
      5:       base_hz = FREQ_W'(440);
      default: base_hz = FREQ_W'(494);
    endcase
  endfunction

  // Each group of seven notes is the base octave shifted up once more.
  // Padding entries past NUM_NOTES keep the variable index fully in range.
  logic [FREQ_W-1:0] rom [ROM_DEPTH];

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    if (g < NUM_NOTES) begin : g_note
      assign rom[g] = base_hz(g % 7) << (g / 7);
    end else begin : g_pad
      assign rom[g] = '0;
    end
  end

  logic             dir_q;   // 1 ascending, 0 descending
  logic             fast_q;
  logic [CNT_W-1:0] timer;

  logic              step;
  logic [IDX_W:0]    idx_x;
  logic [IDX_W:0]    idx_step;
  logic              at_end;
  logic              flip;
  logic              auto_pause;
  logic [IDX_W-1:0]  idx_next;
  logic              dir_next;
  logic              fast_next;
  logic              play_next;
  logic [CNT_W-1:0]  timer_next;
  logic [FREQ_W-1:0] freq_next;
  mode_t             mode_e;

  always_comb begin
    mode_e     = mode_t'(mode);
    idx_x      = {1'b0, note_idx};
    idx_step   = idx_x;
    flip       = 1'b0;
    auto_pause = 1'b0;

    // >= so that switching to a shorter period steps right away
    step   = playing && (timer >= (fast_q ? FAST_M1 : SLOW_M1));
    at_end = dir_q ? (idx_x == IDX_TOP) : (idx_x == '0);

    if (!at_end) begin
      idx_step = dir_q ? idx_x + IDX_ONE : idx_x - IDX_ONE;
    end else begin
      case (mode_e)
        MODE_WRAP:     idx_step = dir_q ? '0 : IDX_TOP;
        MODE_PINGPONG: begin
          flip = 1'b1;
          if (IDX_TOP != '0) idx_step = dir_q ? idx_x - IDX_ONE : idx_x + IDX_ONE;
        end
        MODE_ONESHOT:  auto_pause = 1'b1;
        default:       idx_step = idx_x;
      endcase
    end

    idx_next = note_idx;
    if (step && (idx_step <= IDX_TOP)) idx_next = idx_step[IDX_W-1:0];

    // An explicit direction command outranks the ping-pong flip.
    dir_next = dir_q;
    if (dir_up && !dir_down)      dir_next = 1'b1;
    else if (dir_down && !dir_up) dir_next = 1'b0;
    else if (step && flip)        dir_next = ~dir_q;

    fast_next = fast_q;
    if (speed_fast && !speed_slow)      fast_next = 1'b1;
    else if (speed_slow && !speed_fast) fast_next = 1'b0;

    play_next = playing;
    if (pause_tgl)                play_next = ~playing;
    else if (step && auto_pause)  play_next = 1'b0;

    timer_next = timer;
    if (playing) timer_next = step ? '0 : timer + TMR_ONE;

    freq_next = rom[idx_next];
    if ((MUTE_PAUSE != 0) && !play_next) freq_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      note_idx   <= '0;
      dir_q      <= 1'b1;
      fast_q     <= 1'b0;
      playing    <= 1'b1;
      timer      <= '0;
      step_pulse <= 1'b0;
      freq       <= rom[0];
    end else if (restart) begin
      note_idx   <= '0;
      dir_q      <= 1'b1;
      playing    <= 1'b1;
      timer      <= '0;
      step_pulse <= 1'b0;
      freq       <= rom[0];
    end else begin
      note_idx   <= idx_next;
      dir_q      <= dir_next;
      fast_q     <= fast_next;
      playing    <= play_next;
      timer      <= timer_next;
      step_pulse <= step;
      freq       <= freq_next;
    end
  end

  assign at_top    = ({1'b0, note_idx} == IDX_TOP);
  assign at_bottom = (note_idx == '0);

endmodule

// File: tb/tb_scale_sequencer.sv
module tb_scale_sequencer;

  localparam int NN = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        restart = 1'b0, dir_up = 1'b0, dir_down = 1'b0;
  logic        speed_fast = 1'b0, speed_slow = 1'b0, pause_tgl = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] freq;
  logic [3:0]  note_idx;
  logic        step_pulse, at_top, at_bottom, playing;

  scale_sequencer #(
    .NUM_NOTES(NN), .IDX_W(4), .FREQ_W(32), .CNT_W(31),
    .PERIOD_FAST(4), .PERIOD_SLOW(8), .MUTE_PAUSE(1)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .dir_up(dir_up), .dir_down(dir_down),
    .speed_fast(speed_fast), .speed_slow(speed_slow), .pause_tgl(pause_tgl),
    .mode(mode), .freq(freq), .note_idx(note_idx), .step_pulse(step_pulse),
    .at_top(at_top), .at_bottom(at_bottom), .playing(playing)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state: direction as +1/-1, plain integer counters
  int m_idx, m_dir, m_fast, m_play, m_timer, m_step, m_freq;

  function automatic int hz(input int i);
    int b[7];
    b = '{262, 294, 330, 349, 392, 440, 494};
    return b[i % 7] << (i / 7);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    int per, tgt, n_idx, n_dir, n_play;
    bit stp;
    if (!rst) begin
      m_idx = 0; m_dir = 1; m_fast = 0; m_play = 1; m_timer = 0; m_step = 0; m_freq = hz(0);
    end else if (restart) begin
      m_idx = 0; m_dir = 1; m_play = 1; m_timer = 0; m_step = 0; m_freq = hz(0);
    end else begin
      per = m_fast ? 4 : 8;
      stp = (m_play != 0) && (m_timer >= per - 1);
      n_idx = m_idx; n_dir = m_dir; n_play = m_play;
      if (stp) begin
        tgt = m_idx + m_dir;
        if (tgt >= 0 && tgt <= NN - 1) n_idx = tgt;
        else case (mode)
          2'b01: n_idx = (m_dir > 0) ? 0 : NN - 1;
          2'b10: begin n_dir = -m_dir; n_idx = m_idx - m_dir; end
          2'b11: n_play = 0;
          default: ;
        endcase
      end
      if (m_play != 0) m_timer = stp ? 0 : m_timer + 1;
      if (dir_up && !dir_down) n_dir = 1;
      else if (dir_down && !dir_up) n_dir = -1;
      if (speed_fast && !speed_slow) m_fast = 1;
      else if (speed_slow && !speed_fast) m_fast = 0;
      if (pause_tgl) n_play = (m_play != 0) ? 0 : 1;
      m_idx = n_idx; m_dir = n_dir; m_play = n_play;
      m_step = stp ? 1 : 0;
      m_freq = (m_play != 0) ? hz(m_idx) : 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_pulses(input logic [5:0] p);
    {restart, dir_up, dir_down, speed_fast, speed_slow, pause_tgl} = p;
  endtask

  typedef struct {
    logic [5:0] p;     // {restart, dir_up, dir_down, speed_fast, speed_slow, pause_tgl}
    logic [1:0] md;
    int         n;
    int         idx;
    int         play;
    int         fq;
    int         stp;
  } vec_t;

  localparam logic [5:0] P_NONE = 6'b000000, P_RS = 6'b100000, P_DU = 6'b010000,
                         P_DD = 6'b001000, P_SF = 6'b000100, P_SS = 6'b000010,
                         P_PT = 6'b000001;
  localparam logic [1:0] CL = 2'b00, WR = 2'b01, PP = 2'b10, OS = 2'b11;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{P_NONE,      CL,   8,  1, 1,  294, 1});
    tbl.push_back('{P_NONE,      CL, 104, 14, 1, 1048, 1});
    tbl.push_back('{P_NONE,      CL,   8, 14, 1, 1048, 1});
    tbl.push_back('{P_DD,        CL,   8, 13, 1,  988, 1});
    tbl.push_back('{P_NONE,      CL, 104,  0, 1,  262, 1});
    tbl.push_back('{P_NONE,      CL,   8,  0, 1,  262, 1});
    tbl.push_back('{P_NONE,      WR,   8, 14, 1, 1048, 1});
    tbl.push_back('{P_DU,        WR,   8,  0, 1,  262, 1});
    tbl.push_back('{P_NONE,      WR, 112, 14, 1, 1048, 1});
    tbl.push_back('{P_NONE,      PP,   8, 13, 1,  988, 1});
    tbl.push_back('{P_NONE,      PP,   8, 12, 1,  880, 1});
    tbl.push_back('{P_NONE,      PP,  96,  0, 1,  262, 1});
    tbl.push_back('{P_NONE,      PP,   8,  1, 1,  294, 1});
    tbl.push_back('{P_NONE,      OS, 104, 14, 1, 1048, 1});
    tbl.push_back('{P_NONE,      OS,   8, 14, 0,    0, 1});
    tbl.push_back('{P_NONE,      OS,  20, 14, 0,    0, 0});
    tbl.push_back('{P_PT,        CL,   8, 14, 1, 1048, 0});
    tbl.push_back('{P_NONE,      CL,   1, 14, 1, 1048, 1});
    tbl.push_back('{P_DD,        CL,   6, 14, 1, 1048, 0});
    tbl.push_back('{P_SF,        CL,   1, 14, 1, 1048, 0});
    tbl.push_back('{P_NONE,      CL,   1, 13, 1,  988, 1});
    tbl.push_back('{P_NONE,      CL,   4, 12, 1,  880, 1});
    tbl.push_back('{P_SF | P_SS, CL,   4, 11, 1,  784, 1});
    tbl.push_back('{P_DU | P_DD, CL,   4, 10, 1,  698, 1});
    tbl.push_back('{P_NONE,      CL,   4,  9, 1,  660, 1});
    tbl.push_back('{P_RS | P_SS, CL,   1,  0, 1,  262, 0});
    tbl.push_back('{P_NONE,      CL,   4,  1, 1,  294, 1});
    tbl.push_back('{P_PT,        CL,  10,  1, 0,    0, 0});
    tbl.push_back('{P_PT,        CL,   3,  1, 1,  294, 0});
    tbl.push_back('{P_NONE,      CL,   1,  2, 1,  330, 1});
    tbl.push_back('{P_NONE,      CL,   3,  2, 1,  330, 0});
    tbl.push_back('{P_DD,        CL,   1,  3, 1,  349, 1});
    tbl.push_back('{P_NONE,      CL,   4,  2, 1,  330, 1});

    // reset, with a restart pulse held to show reset wins
    rst = 1'b0; restart = 1'b1;
    cyc(); cyc();
    restart = 1'b0;
    chk("reset idx",    note_idx,   0);
    chk("reset freq",   freq,       262);
    chk("reset step",   step_pulse, 0);
    chk("reset play",   playing,    1);
    chk("reset bottom", at_bottom,  1);
    chk("reset top",    at_top,     0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      mode = tbl[i].md;
      set_pulses(tbl[i].p);
      cyc();
      set_pulses(P_NONE);
      for (int k = 1; k < tbl[i].n; k++) cyc();
      chk($sformatf("row%0d idx",  i), note_idx,   tbl[i].idx);
      chk($sformatf("row%0d play", i), playing,    tbl[i].play);
      chk($sformatf("row%0d freq", i), freq,       tbl[i].fq);
      chk($sformatf("row%0d step", i), step_pulse, tbl[i].stp);
      chk($sformatf("row%0d top",  i), at_top,     (tbl[i].idx == NN - 1) ? 1 : 0);
      chk($sformatf("row%0d bot",  i), at_bottom,  (tbl[i].idx == 0) ? 1 : 0);
    end

    // mid-run reset restores slow speed, index 0, ascending
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("midrst idx",  note_idx, 0);
    chk("midrst freq", freq,     262);
    chk("midrst play", playing,  1);
    chk("midrst step", step_pulse, 0);
    for (int k = 0; k < 7; k++) cyc();
    chk("midrst slow nostep", step_pulse, 0);
    chk("midrst slow idx0",   note_idx,   0);
    cyc();
    chk("midrst slow step", step_pulse, 1);
    chk("midrst slow idx1", note_idx,   1);
    chk("midrst slow freq", freq,       294);

    // randomized run against the reference model
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      rst        = ($urandom_range(599) != 0);
      restart    = ($urandom_range(79) == 0);
      dir_up     = ($urandom_range(15) == 0);
      dir_down   = ($urandom_range(15) == 0);
      speed_fast = ($urandom_range(19) == 0);
      speed_slow = ($urandom_range(23) == 0);
      pause_tgl  = ($urandom_range(29) == 0);
      if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
      cyc();
      chk("rnd idx",  note_idx,   m_idx);
      chk("rnd freq", freq,       m_freq);
      chk("rnd step", step_pulse, m_step);
      chk("rnd play", playing,    m_play);
      chk("rnd top",  at_top,     (m_idx == NN - 1) ? 1 : 0);
      chk("rnd bot",  at_bottom,  (m_idx == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
